// File: rtl/ofm_wr_ctrl.sv
// Packs three per-channel OFM bytes into one zero-padded memory word and writes
// the words of a frame to consecutive addresses. Optional: OFM_WR_CTRL_STALL_CNT_EN.
module ofm_wr_ctrl #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    pix_count,
  input  logic [2:0]          ch_valid,
  input  logic [3*DATA_W-1:0] ch_data,
  output logic [2:0]          ch_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic                done,
  output logic [15:0]         stall_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  localparam int PAD_W = WORD_W - 3*DATA_W;

  logic [1:0]          r_state;
  logic [1:0]          r_slot;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_target;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_buf;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;

  logic [2:0]          w_slot_oh;
  logic [DATA_W-1:0]   w_byte;
  logic                w_xfer;
  logic                w_start;
  logic [CNT_W-1:0]    w_cnt_nxt;

  always_comb begin
    w_slot_oh = 3'b001;
    w_byte    = ch_data[0 +: DATA_W];
    case (r_slot)
      2'd1: begin
        w_slot_oh = 3'b010;
        w_byte    = ch_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        w_slot_oh = 3'b100;
        w_byte    = ch_data[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  // abort masks every handshake in the same cycle so nothing is consumed or written
  assign ch_ready  = (r_state == S_COLLECT && !abort) ? w_slot_oh : 3'b000;
  assign mem_we    = (r_state == S_WRITE) && !abort;
  assign done      = (r_state == S_DONE) && !abort;
  assign busy      = (r_state != S_IDLE);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign w_xfer    = |(ch_valid & ch_ready);
  assign w_start   = (r_state == S_IDLE) && start && !abort;
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_slot      <= 2'd0;
      r_addr      <= '0;
      r_target    <= '0;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_slot  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr   <= base_addr;
            r_target <= pix_count;
            r_cnt    <= '0;
            r_slot   <= 2'd0;
            r_state  <= (pix_count == '0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_xfer) begin
            case (r_slot)
              2'd0: r_buf[2*DATA_W-1:DATA_W] <= w_byte;
              2'd1: r_buf[DATA_W-1:0]        <= w_byte;
              default: begin
                // word and address are captured once so they stay stable while WRITE stalls
                r_mem_wdata <= {{PAD_W{1'b0}}, r_buf, w_byte};
                r_mem_addr  <= r_addr;
                r_state     <= S_WRITE;
              end
            endcase
            r_slot <= (r_slot == 2'd2) ? 2'd0 : r_slot + 1'b1;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            r_addr  <= r_addr + 1'b1;
            r_cnt   <= w_cnt_nxt;
            r_state <= (w_cnt_nxt == r_target) ? S_DONE : S_COLLECT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef OFM_WR_CTRL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = !abort &&
                   ((r_state == S_COLLECT && !(|(ch_valid & w_slot_oh))) ||
                    (r_state == S_WRITE && !mem_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_start) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ofm_wr_ctrl.sv
// Randomized bench for ofm_wr_ctrl: per-channel byte streams are the reference;
// word n of a frame must be {0, ch0[n], ch1[n], ch2[n]} at base+n.
module tb_ofm_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic [15:0] pix_count;
  logic [2:0]  ch_valid;
  logic [23:0] ch_data;
  logic [2:0]  ch_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  ofm_wr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .pix_count(pix_count),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nfail   = 0;

  logic [7:0]  strm [3][64];
  int          idx [3];
  int          vprob, rprob, abort_at, rlo, rhi;
  logic [2:0]  vmask;
  logic [15:0] w_addr [$];
  logic [31:0] w_data [$];
  int          w_cyc [$];
  int          done_cnt, done_cyc, busy_cyc, bad_ready, we_cyc, we_chg, rdy_in_we;
  logic [2:0]  rdy_hist [64];
  logic [15:0] we_a0;
  logic [31:0] we_d0;
  logic        pend;

  task automatic new_streams();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) strm[k][i] = 8'($urandom);
      idx[k] = 0;
    end
  endtask

  task automatic set_defaults();
    vprob = 100; rprob = 100; vmask = 3'b111; abort_at = -1; rlo = -1; rhi = -2;
  endtask

  // Drives one frame (start on cycle 0) and records what the DUT does, cycle by cycle.
  task automatic run_cycles(input logic [15:0] b, input logic [15:0] n, input int max_cyc,
                            input bit stray_start);
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_cyc = 0; bad_ready = 0;
    we_cyc = 0; we_chg = 0; rdy_in_we = 0; pend = 1'b0;
    for (int c = 0; c < 64; c++) rdy_hist[c] = 3'bxxx;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      start     = (c == 0) || (stray_start && $urandom_range(7) == 0);
      base_addr = (c == 0) ? b : 16'($urandom);
      pix_count = (c == 0) ? n : 16'($urandom);
      abort     = (c == abort_at);
      for (int k = 0; k < 3; k++) begin
        ch_valid[k]      = vmask[k] && ($urandom_range(99) < vprob);
        ch_data[k*8 +: 8] = strm[k][idx[k] % 64];
      end
      mem_ready = (c >= rlo && c <= rhi) ? 1'b0 : ($urandom_range(99) < rprob);
      @(negedge clk);
      if (c < 64) rdy_hist[c] = ch_ready;
      if (!(ch_ready inside {3'b000, 3'b001, 3'b010, 3'b100})) bad_ready++;
      for (int k = 0; k < 3; k++) if (ch_valid[k] && ch_ready[k]) idx[k]++;
      if (mem_we) begin
        if (!pend) begin
          we_a0 = mem_addr; we_d0 = mem_wdata;
        end else if (mem_addr !== we_a0 || mem_wdata !== we_d0) begin
          we_chg++;
        end
        we_cyc++;
        if (ch_ready != 3'b000) rdy_in_we++;
        if (mem_ready) begin
          w_addr.push_back(mem_addr); w_data.push_back(mem_wdata); w_cyc.push_back(c);
        end
        pend = !mem_ready;
      end else begin
        pend = 1'b0;
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++; done_cyc = c;
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; ch_valid = 3'b000; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; pix_count = '0;
    ch_valid = '0; ch_data = '0; mem_ready = 1'b0;
    #1;
    nchecks++;
    if ({ch_ready, mem_we, busy, done} !== 6'b0) begin
      nfail++; $display("FAIL reset_ctrl got=%b expected=000000", {ch_ready, mem_we, busy, done});
    end
    nchecks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
      nfail++; $display("FAIL reset_mem got addr=%h data=%h expected 0/0", mem_addr, mem_wdata);
    end
    nchecks++;
    if (stall_cnt !== 16'h0) begin
      nfail++; $display("FAIL reset_stall got=%h expected=0000", stall_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_defaults(); new_streams();
    strm[0][0] = 8'h11; strm[1][0] = 8'h22; strm[2][0] = 8'h33;
    strm[0][1] = 8'h44; strm[1][1] = 8'h55; strm[2][1] = 8'h66;
    run_cycles(16'h0100, 16'd2, 40, 1'b0);
    nchecks++;
    if (w_addr.size() != 2) begin
      nfail++; $display("FAIL basic_count got=%0d expected=2", w_addr.size());
    end else begin
      nchecks++;
      if (w_addr[0] !== 16'h0100 || w_data[0] !== 32'h00112233) begin
        nfail++; $display("FAIL basic_w0 got %h@%h expected 00112233@0100", w_data[0], w_addr[0]);
      end
      nchecks++;
      if (w_addr[1] !== 16'h0101 || w_data[1] !== 32'h00445566) begin
        nfail++; $display("FAIL basic_w1 got %h@%h expected 00445566@0101", w_data[1], w_addr[1]);
      end
      nchecks++;
      if (w_cyc[0] != 4 || done_cyc != w_cyc[1] + 1) begin
        nfail++; $display("FAIL basic_timing got w0=%0d done=%0d expected 4 and %0d", w_cyc[0], done_cyc, w_cyc[1] + 1);
      end
    end
    nchecks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      nfail++; $display("FAIL basic_done got done_cnt=%0d busy=%b expected 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_zero_pix();
    set_defaults(); new_streams();
    run_cycles(16'h0055, 16'd0, 10, 1'b0);
    nchecks++;
    if (we_cyc != 0 || done_cyc != 1 || busy_cyc != 1 || done_cnt != 1) begin
      nfail++; $display("FAIL zero_pix got we=%0d done_cyc=%0d busy=%0d done_cnt=%0d expected 0/1/1/1",
                        we_cyc, done_cyc, busy_cyc, done_cnt);
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_stall;
    set_defaults(); new_streams();
    rlo = 4; rhi = 6;
    run_cycles(16'h0200, 16'd1, 30, 1'b0);
    nchecks++;
    if (we_cyc != 4 || we_chg != 0 || rdy_in_we != 0) begin
      nfail++; $display("FAIL stall_hold got we=%0d chg=%0d rdy=%0d expected 4/0/0", we_cyc, we_chg, rdy_in_we);
    end
    nchecks++;
    if (w_addr.size() != 1 || w_cyc[0] != 7 || w_addr[0] !== 16'h0200 ||
        w_data[0] !== {8'h00, strm[0][0], strm[1][0], strm[2][0]}) begin
      nfail++; $display("FAIL stall_write got n=%0d data=%h expected 1 write of %h at cycle 7",
                        w_addr.size(), (w_data.size() > 0) ? w_data[0] : 32'hx,
                        {8'h00, strm[0][0], strm[1][0], strm[2][0]});
    end
`ifdef OFM_WR_CTRL_STALL_CNT_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    nchecks++;
    if (stall_cnt !== exp_stall) begin
      nfail++; $display("FAIL stall_cnt got=%0d expected=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_holdoff();
    int bad;
    set_defaults(); new_streams();
    vmask = 3'b110; abort_at = 8;
    run_cycles(16'h0010, 16'd1, 10, 1'b0);
    bad = 0;
    for (int c = 1; c < 8; c++) if (rdy_hist[c] !== 3'b001) bad++;
    nchecks++;
    if (bad != 0 || rdy_hist[8] !== 3'b000) begin
      nfail++; $display("FAIL holdoff_ready got bad=%0d abort_rdy=%b expected 0/000", bad, rdy_hist[8]);
    end
    nchecks++;
    if (we_cyc != 0 || idx[0] != 0 || idx[1] != 0 || idx[2] != 0 || done_cnt != 0) begin
      nfail++; $display("FAIL holdoff_consume got we=%0d idx=%0d,%0d,%0d done=%0d expected all 0",
                        we_cyc, idx[0], idx[1], idx[2], done_cnt);
    end
  endtask

  task automatic test_wrap();
    set_defaults(); new_streams();
    run_cycles(16'hFFFF, 16'd2, 40, 1'b0);
    nchecks++;
    if (w_addr.size() != 2 || w_addr[0] !== 16'hFFFF || w_addr[1] !== 16'h0000 ||
        w_data[1] !== {8'h00, strm[0][1], strm[1][1], strm[2][1]}) begin
      nfail++; $display("FAIL wrap got n=%0d a0=%h a1=%h expected FFFF then 0000", w_addr.size(),
                        (w_addr.size() > 0) ? w_addr[0] : 16'hx, (w_addr.size() > 1) ? w_addr[1] : 16'hx);
    end
  endtask

  task automatic test_abort();
    set_defaults(); new_streams();
    abort_at = 3;
    run_cycles(16'h0300, 16'd4, 6, 1'b0);
    nchecks++;
    if (done_cnt != 0 || rdy_hist[3] !== 3'b000 || we_cyc != 0 || busy !== 1'b0) begin
      nfail++; $display("FAIL abort_flush got done=%0d rdy=%b we=%0d busy=%b expected 0/000/0/0",
                        done_cnt, rdy_hist[3], we_cyc, busy);
    end
    nchecks++;
    if (idx[0] != 1 || idx[1] != 1 || idx[2] != 0) begin
      nfail++; $display("FAIL abort_consumed got %0d,%0d,%0d expected 1,1,0", idx[0], idx[1], idx[2]);
    end
    set_defaults(); new_streams();
    run_cycles(16'h0400, 16'd1, 30, 1'b0);
    nchecks++;
    if (w_addr.size() != 1 || w_addr[0] !== 16'h0400 || done_cnt != 1 ||
        w_data[0] !== {8'h00, strm[0][0], strm[1][0], strm[2][0]}) begin
      nfail++; $display("FAIL abort_restart got n=%0d data=%h expected %h@0400",
                        w_addr.size(), (w_data.size() > 0) ? w_data[0] : 32'hx,
                        {8'h00, strm[0][0], strm[1][0], strm[2][0]});
    end
  endtask

  task automatic test_mid_reset();
    int act;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0700; pix_count = 16'd3; ch_valid = 3'b111; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nchecks++;
    if (busy !== 1'b0 || ch_ready !== 3'b000 || mem_addr !== 16'h0) begin
      nfail++; $display("FAIL midreset_async got busy=%b rdy=%b addr=%h expected 0/000/0000", busy, ch_ready, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || mem_we || ch_ready != 3'b000) act++;
    end
    nchecks++;
    if (act != 0) begin
      nfail++; $display("FAIL midreset_idle got active_cycles=%0d expected=0", act);
    end
    ch_valid = 3'b000; mem_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] b;
    int n, bad;
    for (int f = 0; f < 10; f++) begin
      set_defaults(); new_streams();
      vprob = $urandom_range(40, 100); rprob = $urandom_range(30, 100);
      b = 16'($urandom); n = $urandom_range(1, 10);
      run_cycles(b, 16'(n), 400, 1'b1);
      bad = 0;
      if (w_addr.size() == n) begin
        for (int i = 0; i < n; i++)
          if (w_addr[i] !== 16'(b + i) || w_data[i] !== {8'h00, strm[0][i], strm[1][i], strm[2][i]}) bad++;
      end
      nchecks++;
      if (w_addr.size() != n || bad != 0) begin
        nfail++; $display("FAIL rand_writes frame=%0d got n=%0d bad=%0d expected n=%0d bad=0", f, w_addr.size(), bad, n);
      end
      nchecks++;
      if (done_cnt != 1 || bad_ready != 0 || rdy_in_we != 0 || we_chg != 0 ||
          (w_cyc.size() > 0 && done_cyc != w_cyc[w_cyc.size()-1] + 1)) begin
        nfail++; $display("FAIL rand_ctrl frame=%0d got done=%0d badrdy=%0d rdywe=%0d chg=%0d done_cyc=%0d",
                          f, done_cnt, bad_ready, rdy_in_we, we_chg, done_cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_pix();
    test_stall();
    test_holdoff();
    test_wrap();
    test_abort();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
